// File: rtl/ks_pluck_sequencer.sv
// Step sequencer for the Karplus-Strong voice: walks a small period table at a
// tempo counted in sample strobes, updating ks_period and pulsing ks_pluck per step.
module ks_pluck_sequencer #(
  parameter int NUM_STEPS     = 8,
  parameter int STEP_AW       = 3,
  parameter int KS_DATA_WIDTH = 8,
  parameter int TEMPO_WIDTH   = 12,
  parameter int PLUCK_SAMPLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_stb,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [STEP_AW-1:0]       last_step,
  input  logic [TEMPO_WIDTH-1:0]   tempo,
  input  logic                     tbl_we,
  input  logic [STEP_AW-1:0]       tbl_addr,
  input  logic [KS_DATA_WIDTH-1:0] tbl_wdata,
  output logic [KS_DATA_WIDTH-1:0] ks_period,
  output logic                     ks_pluck,
  output logic                     busy,
  output logic [STEP_AW-1:0]       step_idx,
  output logic                     done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [TEMPO_WIDTH-1:0] PLUCK_CNT = TEMPO_WIDTH'(PLUCK_SAMPLES);
  localparam logic [TEMPO_WIDTH-1:0] ONE       = TEMPO_WIDTH'(1);

  logic [1:0]               state;
  logic [TEMPO_WIDTH-1:0]   cnt;
  logic [TEMPO_WIDTH-1:0]   eff_tempo;
  logic [KS_DATA_WIDTH-1:0] tbl [NUM_STEPS];
  logic [KS_DATA_WIDTH-1:0] cur_period;
  logic [TEMPO_WIDTH-1:0]   cnt_inc;

  // NOTE: the table is plain storage and deliberately has no reset; software
  // loads it before starting, and leaving it unreset keeps it a simple RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
  end

  assign cur_period = tbl[step_idx];
  assign cnt_inc    = cnt + ONE;
  assign busy       = (state == S_LOAD) || (state == S_PLAY);
  assign done       = (state == S_DONE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      eff_tempo <= ONE;
      ks_period <= '0;
      ks_pluck  <= 1'b0;
      step_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            step_idx <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (stop) begin
            ks_pluck <= 1'b0;
            state    <= S_IDLE;
          end else begin
            eff_tempo <= (tempo == '0) ? ONE : tempo;
            cnt       <= '0;
            // A zero entry is a rest: keep the old period and do not pluck.
            if (cur_period != '0) begin
              ks_period <= cur_period;
              ks_pluck  <= 1'b1;
            end
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (stop) begin
            ks_pluck <= 1'b0;
            state    <= S_IDLE;
          end else if (sample_stb) begin
            if (cnt == eff_tempo - ONE) begin
              // Step advance; also ends a pluck longer than the step itself.
              ks_pluck <= 1'b0;
              if (step_idx != last_step) begin
                step_idx <= step_idx + STEP_AW'(1);
                state    <= S_LOAD;
              end else if (loop_en) begin
                step_idx <= '0;
                state    <= S_LOAD;
              end else begin
                state <= S_DONE;
              end
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == PLUCK_CNT) ks_pluck <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ks_pluck_sequencer.sv
// Directed bench for ks_pluck_sequencer: playback order, pluck length, looping,
// stop/start interplay, tempo=0, full-length wrap, live table edits and reset.
module tb_ks_pluck_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_stb = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [2:0] last_step = '0;
  logic [11:0] tempo = '0;
  logic       tbl_we = 1'b0;
  logic [2:0] tbl_addr = '0;
  logic [7:0] tbl_wdata = '0;
  logic [7:0] ks_period;
  logic       ks_pluck;
  logic       busy;
  logic [2:0] step_idx;
  logic       done;

  int total = 0;
  int bad = 0;

  ks_pluck_sequencer dut (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .start(start), .stop(stop),
    .loop_en(loop_en), .last_step(last_step), .tempo(tempo), .tbl_we(tbl_we),
    .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .ks_period(ks_period),
    .ks_pluck(ks_pluck), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    tbl_we = 1'b1; tbl_addr = 3'(a); tbl_wdata = 8'(d);
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered with the DUT in LOAD for step idx. Plays eff strobes; returns after
  // the advancing strobe so the caller checks where it went.
  task automatic play_step(input string tag, input int idx, input int period,
                           input int pl, input int eff);
    check({tag, " load idx"}, step_idx, idx);
    check({tag, " load busy"}, busy, 1);
    check({tag, " load pluck"}, ks_pluck, 0);
    tick();
    check({tag, " period"}, ks_period, period);
    check({tag, " pluck on"}, ks_pluck, pl);
    for (int j = 1; j < eff; j++) begin
      strobe();
      check({tag, " pluck strobe"}, ks_pluck, (pl != 0 && j < 2) ? 1 : 0);
      tick();
      check({tag, " pluck idle"}, ks_pluck, (pl != 0 && j < 2) ? 1 : 0);
    end
    strobe();
  endtask

  task automatic check_idle(input string tag, input int period);
    check({tag, " busy"}, busy, 0);
    check({tag, " pluck"}, ks_pluck, 0);
    check({tag, " done"}, done, 0);
    check({tag, " period"}, ks_period, period);
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst period", ks_period, 0);
    check("rst pluck", ks_pluck, 0);
    check("rst busy", busy, 0);
    check("rst idx", step_idx, 0);
    check("rst done", done, 0);
    rst = 1'b0;

    // Basic one-shot sequence with a rest at step 1
    wr(0, 32); wr(1, 0); wr(2, 48); wr(3, 24);
    last_step = 3; tempo = 4; loop_en = 0;
    go();
    play_step("s0", 0, 32, 1, 4);
    play_step("s1", 1, 32, 0, 4);
    play_step("s2", 2, 48, 1, 4);
    play_step("s3", 3, 24, 1, 4);
    check("end done", done, 1);
    check("end busy", busy, 0);
    check("end period", ks_period, 24);
    tick();
    check_idle("after done", 24);
    tick();
    check("done once", done, 0);

    // Looping two steps, then stop mid-PLAY
    wr(0, 10); wr(1, 20);
    last_step = 1; loop_en = 1; tempo = 2;
    go();
    for (int r = 0; r < 2; r++) begin
      play_step("lp0", 0, 10, 1, 2);
      check("lp no done", done, 0);
      play_step("lp1", 1, 20, 1, 2);
      check("lp no done", done, 0);
    end
    check("lp wrap idx", step_idx, 0);
    tick();
    check("lp pluck before stop", ks_pluck, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop", 10);
    tick();
    check("stop stays idle", busy, 0);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", busy, 0);
    tick();
    check("start+stop still idle", busy, 0);

    // tempo=0 behaves as 1: one-strobe steps and one-strobe plucks
    wr(0, 5); wr(1, 6);
    last_step = 1; loop_en = 0; tempo = 0;
    go();
    play_step("t0a", 0, 5, 1, 1);
    check("t0 pluck off at advance", ks_pluck, 0);
    play_step("t0b", 1, 6, 1, 1);
    check("t0 done", done, 1);
    tick();

    // Full 8-step table wraps under loop_en
    for (int i = 0; i < 8; i++) wr(i, 100 + i);
    last_step = 7; loop_en = 1; tempo = 1;
    go();
    for (int i = 0; i < 8; i++) play_step("wrap", i, 100 + i, 1, 1);
    check("wrap idx", step_idx, 0);
    check("wrap busy", busy, 1);
    tick();
    check("wrap period", ks_period, 100);
    stop = 1'b1; tick(); stop = 1'b0;
    check_idle("wrap stop", 100);

    // Live edit while playing step 0, plus start while busy
    wr(0, 40); wr(1, 50);
    last_step = 1; loop_en = 0; tempo = 3;
    go();
    tick();
    check("live period0", ks_period, 40);
    wr(1, 99);
    strobe();
    go();
    check("busy start idx", step_idx, 0);
    check("busy start busy", busy, 1);
    check("busy start pluck", ks_pluck, 1);
    strobe();
    check("live pluck off", ks_pluck, 0);
    strobe();
    play_step("live1", 1, 99, 1, 3);
    check("live done", done, 1);
    tick();

    // Reset mid-PLAY with pluck active
    go();
    tick();
    check("pre-rst pluck", ks_pluck, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst period", ks_period, 0);
    check("mrst pluck", ks_pluck, 0);
    check("mrst busy", busy, 0);
    check("mrst idx", step_idx, 0);
    check("mrst done", done, 0);
    tick();
    check("mrst idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
